// File: rtl/uart_rx_ctrl_gen.sv
// UART receive controller: frame FSM, oversampled 2-of-3 bit voting, deserializer,
// parity/stop checking and line-break detection, all in the rx_clk domain.
module uart_rx_ctrl_gen #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PRESCALE_W = 6
) (
    input  logic                  rx_clk,
    input  logic                  rst_n,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  parity_enable,
    input  logic                  parity_type,
    input  logic                  stop_bits2,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_valid,
    output logic                  parity_error,
    output logic                  stop_error,
    output logic                  break_detect,
    output logic                  busy
);
    localparam int unsigned BitCntW = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {
        StIdle, StStart, StData, StParity, StStop1, StStop2, StDone
    } state_e;
    typedef enum logic [1:0] {Os8, Os16, Os32} os_e;

    state_e                state_q, state_d;
    os_e                   os_q, os_d, os_in;
    logic                  par_en_q, par_en_d, par_type_q, par_type_d, stop2_q, stop2_d;
    logic [4:0]            edge_cnt_q, edge_cnt_d;
    logic [BitCntW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d, p_data_q, p_data_d;
    logic [1:0]            smp_q, smp_d;
    logic                  bit_q, bit_d, par_bit_q, par_bit_d, stop1_bit_q, stop1_bit_d;
    logic                  par_err_q, par_err_d, stp_err_q, stp_err_d;
    logic                  dv_q, dv_d, pe_q, pe_d, se_q, se_d, bd_q, bd_d, busy_q, busy_d;

    logic [4:0] last_cnt, mid_cnt;
    logic       vote, at_mid, at_last, is_break, start_frame, enter_done;

    // Unsupported prescale values fall back to 8x oversampling.
    always_comb begin
        if (32'(prescale) == 32'd16) begin
            os_in = Os16;
        end else if (32'(prescale) == 32'd32) begin
            os_in = Os32;
        end else begin
            os_in = Os8;
        end
    end

    always_comb begin
        case (os_q)
            Os16:    begin last_cnt = 5'd15; mid_cnt = 5'd8;  end
            Os32:    begin last_cnt = 5'd31; mid_cnt = 5'd16; end
            default: begin last_cnt = 5'd7;  mid_cnt = 5'd4;  end
        endcase
    end

    // Third sample is the live line at mid-bit, so the vote resolves without extra latency.
    assign vote     = (smp_q[0] & smp_q[1]) | (rx_in & (smp_q[0] | smp_q[1]));
    assign at_mid   = (edge_cnt_q == mid_cnt);
    assign at_last  = (edge_cnt_q == last_cnt);
    assign is_break = (shift_q == '0) && !(par_en_q && par_bit_q) && !stop1_bit_q;

    always_comb begin
        state_d     = state_q;
        os_d        = os_q;
        par_en_d    = par_en_q;
        par_type_d  = par_type_q;
        stop2_d     = stop2_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        p_data_d    = p_data_q;
        smp_d       = smp_q;
        bit_d       = bit_q;
        par_bit_d   = par_bit_q;
        stop1_bit_d = stop1_bit_q;
        par_err_d   = par_err_q;
        stp_err_d   = stp_err_q;
        dv_d        = 1'b0;
        pe_d        = 1'b0;
        se_d        = 1'b0;
        bd_d        = 1'b0;
        start_frame = 1'b0;
        enter_done  = 1'b0;
        edge_cnt_d  = at_last ? 5'd0 : edge_cnt_q + 5'd1;

        if (edge_cnt_q == mid_cnt - 5'd2) smp_d[0] = rx_in;
        if (edge_cnt_q == mid_cnt - 5'd1) smp_d[1] = rx_in;
        if (at_mid) bit_d = vote;

        case (state_q)
            StIdle: begin
                edge_cnt_d = 5'd0;
                if (!rx_in) start_frame = 1'b1;
            end
            StStart: begin
                if (at_mid && vote) begin
                    state_d    = StIdle;
                    edge_cnt_d = 5'd0;
                end else if (at_last) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (at_last) begin
                    shift_d = {bit_q, shift_q[DATA_WIDTH-1:1]};
                    if (bit_cnt_q == BitCntW'(DATA_WIDTH - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? StParity : StStop1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BitCntW'(1);
                    end
                end
            end
            StParity: begin
                if (at_mid) begin
                    par_bit_d = vote;
                    if (vote != (^shift_q ^ par_type_q)) par_err_d = 1'b1;
                end
                if (at_last) state_d = StStop1;
            end
            StStop1: begin
                if (at_mid) begin
                    stop1_bit_d = vote;
                    if (!vote) stp_err_d = 1'b1;
                end
                if (at_last) begin
                    if (stop2_q) state_d = StStop2;
                    else         enter_done = 1'b1;
                end
            end
            StStop2: begin
                if (at_mid && !vote) stp_err_d = 1'b1;
                if (at_last) enter_done = 1'b1;
            end
            StDone: begin
                edge_cnt_d = 5'd0;
                par_err_d  = 1'b0;
                stp_err_d  = 1'b0;
                if (!rx_in) start_frame = 1'b1;
                else        state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (enter_done) begin
            state_d = StDone;
            if (is_break) begin
                bd_d = 1'b1;
            end else begin
                pe_d = par_err_q;
                se_d = stp_err_q;
                if (!par_err_q && !stp_err_q) begin
                    dv_d     = 1'b1;
                    p_data_d = shift_q;
                end
            end
        end

        // Frame configuration is frozen here for the whole frame.
        if (start_frame) begin
            state_d    = StStart;
            os_d       = os_in;
            par_en_d   = parity_enable;
            par_type_d = parity_type;
            stop2_d    = stop_bits2;
            edge_cnt_d = 5'd0;
            bit_cnt_d  = '0;
            par_err_d  = 1'b0;
            stp_err_d  = 1'b0;
        end

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            os_q        <= Os8;
            par_en_q    <= 1'b0;
            par_type_q  <= 1'b0;
            stop2_q     <= 1'b0;
            edge_cnt_q  <= 5'd0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            p_data_q    <= '0;
            smp_q       <= 2'b00;
            bit_q       <= 1'b0;
            par_bit_q   <= 1'b0;
            stop1_bit_q <= 1'b0;
            par_err_q   <= 1'b0;
            stp_err_q   <= 1'b0;
            dv_q        <= 1'b0;
            pe_q        <= 1'b0;
            se_q        <= 1'b0;
            bd_q        <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            os_q        <= os_d;
            par_en_q    <= par_en_d;
            par_type_q  <= par_type_d;
            stop2_q     <= stop2_d;
            edge_cnt_q  <= edge_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            p_data_q    <= p_data_d;
            smp_q       <= smp_d;
            bit_q       <= bit_d;
            par_bit_q   <= par_bit_d;
            stop1_bit_q <= stop1_bit_d;
            par_err_q   <= par_err_d;
            stp_err_q   <= stp_err_d;
            dv_q        <= dv_d;
            pe_q        <= pe_d;
            se_q        <= se_d;
            bd_q        <= bd_d;
            busy_q      <= busy_d;
        end
    end

    assign p_data       = p_data_q;
    assign data_valid   = dv_q;
    assign parity_error = pe_q;
    assign stop_error   = se_q;
    assign break_detect = bd_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_uart_rx_ctrl_gen.sv
// Directed bench for uart_rx_ctrl_gen: a table of single frames plus hand-written
// glitch, break, back-to-back and mid-frame reset sequences.
module tb_uart_rx_ctrl_gen;
    logic       rx_clk = 1'b0;
    logic       rst_n;
    logic       rx_in;
    logic [5:0] prescale;
    logic       parity_enable, parity_type, stop_bits2;

    logic [7:0] p_data8;
    logic       dv8, pe8, se8, bd8, busy8;
    logic [6:0] p_data7;
    logic       dv7, pe7, se7, bd7, busy7;

    uart_rx_ctrl_gen #(.DATA_WIDTH(8), .PRESCALE_W(6)) u_dut8 (
        .rx_clk       (rx_clk),
        .rst_n        (rst_n),
        .rx_in        (rx_in),
        .prescale     (prescale),
        .parity_enable(parity_enable),
        .parity_type  (parity_type),
        .stop_bits2   (stop_bits2),
        .p_data       (p_data8),
        .data_valid   (dv8),
        .parity_error (pe8),
        .stop_error   (se8),
        .break_detect (bd8),
        .busy         (busy8)
    );

    uart_rx_ctrl_gen #(.DATA_WIDTH(7), .PRESCALE_W(6)) u_dut7 (
        .rx_clk       (rx_clk),
        .rst_n        (rst_n),
        .rx_in        (rx_in),
        .prescale     (prescale),
        .parity_enable(parity_enable),
        .parity_type  (parity_type),
        .stop_bits2   (stop_bits2),
        .p_data       (p_data7),
        .data_valid   (dv7),
        .parity_error (pe7),
        .stop_error   (se7),
        .break_detect (bd7),
        .busy         (busy7)
    );

    always #5 rx_clk = ~rx_clk;

    int         n_cmp = 0;
    int         n_fail = 0;
    bit         line_q[$];
    int         dv_cyc[$], pe_cyc[$], se_cyc[$], bd_cyc[$];
    logic [8:0] dv_dat[$];
    bit         busy_tr[$];
    logic [5:0] cfg_ps;
    bit         cfg_pen, cfg_ptype, cfg_st2;

    typedef struct {
        logic [5:0] ps;
        int         bitlen;
        bit         pen, ptype, st2, flip_par, bad_stop;
        logic [8:0] data;
        int         done_cyc;
        bit         exp_dv, exp_pe, exp_se;
        logic [8:0] exp_pd;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_frame(input logic [8:0] data, input int w, input bit pen,
                             input bit ptype, input bit st2, input bit flip_par,
                             input bit bad_stop);
        bit par;
        par = ptype;
        line_q.push_back(1'b0);
        for (int i = 0; i < w; i++) begin
            line_q.push_back(data[i]);
            par ^= data[i];
        end
        if (pen) line_q.push_back(par ^ flip_par);
        line_q.push_back(!bad_stop);
        if (st2) line_q.push_back(1'b1);
    endtask

    // Drives line_q (bitlen cycles per entry, idle high afterwards) and logs outputs per cycle.
    // Cycle 0 is the cycle in which the first line value is presented.
    task automatic run_line(input int bitlen, input int ncyc, input bit use7,
                            input int scr_lo, input int scr_hi);
        logic       dv, pe, se, bd, bz;
        logic [8:0] pd;
        dv_cyc.delete(); pe_cyc.delete(); se_cyc.delete(); bd_cyc.delete();
        dv_dat.delete(); busy_tr.delete();
        prescale = cfg_ps; parity_enable = cfg_pen; parity_type = cfg_ptype; stop_bits2 = cfg_st2;
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            @(negedge rx_clk);
            if (use7) begin
                dv = dv7; pe = pe7; se = se7; bd = bd7; bz = busy7; pd = {2'b00, p_data7};
            end else begin
                dv = dv8; pe = pe8; se = se8; bd = bd8; bz = busy8; pd = {1'b0, p_data8};
            end
            if (dv === 1'b1) begin dv_cyc.push_back(cyc); dv_dat.push_back(pd); end
            if (pe === 1'b1) pe_cyc.push_back(cyc);
            if (se === 1'b1) se_cyc.push_back(cyc);
            if (bd === 1'b1) bd_cyc.push_back(cyc);
            busy_tr.push_back(bz === 1'b1);
            rx_in = ((cyc / bitlen) < line_q.size()) ? line_q[cyc / bitlen] : 1'b1;
            // Mid-frame config changes must not disturb the frame in flight.
            if (cyc >= scr_lo && cyc < scr_hi) begin
                prescale      = (cfg_ps == 6'd32) ? 6'd16 : 6'd32;
                parity_enable = ~cfg_pen;
                parity_type   = ~cfg_ptype;
                stop_bits2    = ~cfg_st2;
            end else begin
                prescale = cfg_ps; parity_enable = cfg_pen;
                parity_type = cfg_ptype; stop_bits2 = cfg_st2;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rx_in = 1'b1;
        repeat (3) @(negedge rx_clk);
        rst_n = 1'b1;
        repeat (2) @(negedge rx_clk);
    endtask

    task automatic set_cfg(input logic [5:0] ps, input bit pen, input bit ptype, input bit st2);
        cfg_ps = ps; cfg_pen = pen; cfg_ptype = ptype; cfg_st2 = st2;
    endtask

    initial begin
        //           ps    bl  pen pty st2 flp bst data     done dv pe se exp_pd
        vecs[0] = '{6'd8,  8,  0,  0,  0,  0,  0,  9'h0A5,  81, 1, 0, 0, 9'h0A5};
        vecs[1] = '{6'd16, 16, 1,  0,  0,  1,  0,  9'h03C, 177, 0, 1, 0, 9'h0A5};
        vecs[2] = '{6'd8,  8,  0,  0,  0,  0,  1,  9'h012,  81, 0, 0, 1, 9'h0A5};
        vecs[3] = '{6'd16, 16, 1,  1,  0,  0,  0,  9'h0C3, 177, 1, 0, 0, 9'h0C3};
        vecs[4] = '{6'd10, 8,  1,  0,  1,  0,  0,  9'h001,  97, 1, 0, 0, 9'h001};
        vecs[5] = '{6'd32, 32, 0,  0,  1,  0,  0,  9'h0FF, 353, 1, 0, 0, 9'h0FF};

        set_cfg(6'd8, 1'b0, 1'b0, 1'b0);
        prescale = 6'd8; parity_enable = 1'b0; parity_type = 1'b0; stop_bits2 = 1'b0;
        do_reset();
        check("reset_p_data", 32'(p_data8), 32'h0);
        check("reset_busy", 32'(busy8), 32'h0);

        // Back-to-back 7O1 at 32x on the 7-bit instance, no idle gap between frames.
        set_cfg(6'd32, 1'b1, 1'b1, 1'b0);
        line_q.delete();
        add_frame(9'h055, 7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        add_frame(9'h02A, 7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        run_line(32, 700, 1'b1, 5, 300);
        check("b2b_dv_count", 32'(dv_cyc.size()), 32'd2);
        if (dv_cyc.size() == 2) begin
            check("b2b_dv0_cycle", 32'(dv_cyc[0]), 32'd321);
            check("b2b_dv1_cycle", 32'(dv_cyc[1]), 32'd642);
            check("b2b_dv0_data", 32'(dv_dat[0]), 32'h55);
            check("b2b_dv1_data", 32'(dv_dat[1]), 32'h2A);
        end
        check("b2b_err_count", 32'(pe_cyc.size() + se_cyc.size() + bd_cyc.size()), 32'd0);
        check("b2b_busy_done1", 32'(busy_tr[321]), 32'd1);
        check("b2b_busy_restart", 32'(busy_tr[322]), 32'd1);
        check("b2b_busy_idle", 32'(busy_tr[643]), 32'd0);

        // Start glitch: three low cycles at 16x.
        do_reset();
        set_cfg(6'd16, 1'b0, 1'b0, 1'b0);
        line_q.delete();
        repeat (3) line_q.push_back(1'b0);
        run_line(1, 30, 1'b0, 0, 0);
        check("glitch_pulses", 32'(dv_cyc.size() + pe_cyc.size() + se_cyc.size()
                                   + bd_cyc.size()), 32'd0);
        check("glitch_busy_c1", 32'(busy_tr[1]), 32'd1);
        check("glitch_busy_c9", 32'(busy_tr[9]), 32'd1);
        check("glitch_busy_c10", 32'(busy_tr[10]), 32'd0);

        // Break: 8N2 at 8x, line low for 12 bit-times, then high.
        set_cfg(6'd8, 1'b0, 1'b0, 1'b1);
        line_q.delete();
        repeat (12) line_q.push_back(1'b0);
        run_line(8, 200, 1'b0, 5, 80);
        check("brk_bd_count", 32'(bd_cyc.size()), 32'd1);
        if (bd_cyc.size() > 0) check("brk_bd_cycle", 32'(bd_cyc[0]), 32'd89);
        check("brk_se_count", 32'(se_cyc.size()), 32'd0);
        check("brk_pe_count", 32'(pe_cyc.size()), 32'd0);
        check("brk_busy_done", 32'(busy_tr[89]), 32'd1);
        check("brk_busy_restart", 32'(busy_tr[90]), 32'd1);
        check("brk_dv_count", 32'(dv_cyc.size()), 32'd1);
        if (dv_cyc.size() > 0) begin
            check("brk_dv_cycle", 32'(dv_cyc[0]), 32'd178);
            check("brk_dv_data", 32'(dv_dat[0]), 32'hFF);
        end

        // Single-frame table, 8-bit instance, run back to back without reset.
        foreach (vecs[i]) begin
            set_cfg(vecs[i].ps, vecs[i].pen, vecs[i].ptype, vecs[i].st2);
            line_q.delete();
            add_frame(vecs[i].data, 8, vecs[i].pen, vecs[i].ptype, vecs[i].st2,
                      vecs[i].flip_par, vecs[i].bad_stop);
            run_line(vecs[i].bitlen, line_q.size() * vecs[i].bitlen + 24, 1'b0,
                     5, vecs[i].done_cyc - 5);
            check($sformatf("v%0d_dv_count", i), 32'(dv_cyc.size()), 32'(vecs[i].exp_dv));
            check($sformatf("v%0d_pe_count", i), 32'(pe_cyc.size()), 32'(vecs[i].exp_pe));
            check($sformatf("v%0d_se_count", i), 32'(se_cyc.size()), 32'(vecs[i].exp_se));
            check($sformatf("v%0d_bd_count", i), 32'(bd_cyc.size()), 32'd0);
            if (dv_cyc.size() > 0) begin
                check($sformatf("v%0d_dv_cycle", i), 32'(dv_cyc[0]), 32'(vecs[i].done_cyc));
                check($sformatf("v%0d_dv_data", i), 32'(dv_dat[0]), 32'(vecs[i].exp_pd));
            end
            if (pe_cyc.size() > 0)
                check($sformatf("v%0d_pe_cycle", i), 32'(pe_cyc[0]), 32'(vecs[i].done_cyc));
            if (se_cyc.size() > 0)
                check($sformatf("v%0d_se_cycle", i), 32'(se_cyc[0]), 32'(vecs[i].done_cyc));
            check($sformatf("v%0d_p_data", i), 32'(p_data8), 32'(vecs[i].exp_pd));
            check($sformatf("v%0d_busy_c1", i), 32'(busy_tr[1]), 32'd1);
            check($sformatf("v%0d_busy_done", i), 32'(busy_tr[vecs[i].done_cyc]), 32'd1);
            check($sformatf("v%0d_busy_idle", i), 32'(busy_tr[vecs[i].done_cyc + 1]), 32'd0);
        end

        // Reset in DATA bit 4, then a clean 0x81 frame.
        set_cfg(6'd8, 1'b0, 1'b0, 1'b0);
        line_q.delete();
        add_frame(9'h0FF, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_line(8, 45, 1'b0, 0, 0);
        check("rst_busy_before", 32'(busy8), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_p_data", 32'(p_data8), 32'h0);
        check("rst_flags", 32'({dv8, pe8, se8, bd8, busy8}), 32'h0);
        rx_in = 1'b1;
        repeat (2) @(negedge rx_clk);
        rst_n = 1'b1;
        repeat (2) @(negedge rx_clk);
        line_q.delete();
        add_frame(9'h081, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_line(8, 110, 1'b0, 5, 70);
        check("post_rst_dv_count", 32'(dv_cyc.size()), 32'd1);
        if (dv_cyc.size() > 0) begin
            check("post_rst_dv_cycle", 32'(dv_cyc[0]), 32'd81);
            check("post_rst_dv_data", 32'(dv_dat[0]), 32'h81);
        end
        check("post_rst_err_count", 32'(pe_cyc.size() + se_cyc.size() + bd_cyc.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
